// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a valid/ready word load and a bit-rate tick.
// Latency: a word accepted at edge N emits its first bit at the first later edge with shift_en_i=1.
// Backpressure: load_ready_o is high in IDLE, or on the final-bit tick so frames run back to back.
//
// Ports:
//   clk_i          rising-edge clock
//   reset_i        synchronous, active-high reset
//   load_valid_i   producer presents parallel_in_i
//   load_ready_o   word can be accepted this cycle (combinational)
//   parallel_in_i  word to serialize, sampled only on an accepted load
//   shift_en_i     bit-rate tick, one bit is emitted per tick
//   serial_out_o   registered serial data (IDLE_LEVEL between frames)
//   serial_valid_o one-cycle strobe, serial_out_o carries a new bit
//   last_bit_o     one-cycle strobe on the final bit of a word
//   busy_o         frame in progress
module piso_serializer #(
  parameter int   WIDTH      = 8,
  parameter bit   LSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [WIDTH-1:0] parallel_in_i,
  input  logic             shift_en_i,
  output logic             serial_out_o,
  output logic             serial_valid_o,
  output logic             last_bit_o,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               serial_out_q, serial_out_d;
  logic               serial_valid_q, serial_valid_d;
  logic               last_bit_q, last_bit_d;

  logic               final_tick;
  logic               accept;
  logic               out_bit;
  logic [WIDTH-1:0]   shreg_shifted;

  // The final-bit tick frees the shift register, so a new word may be
  // loaded in that same cycle and start on the very next tick.
  assign final_tick   = (state_q == SHIFT) && shift_en_i && (bit_cnt_q == LAST_CNT);
  assign load_ready_o = (state_q == IDLE) || final_tick;
  assign accept       = load_valid_i && load_ready_o;

  assign out_bit       = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
  assign shreg_shifted = LSB_FIRST ? {1'b0, shreg_q[WIDTH-1:1]}
                                   : {shreg_q[WIDTH-2:0], 1'b0};

  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    bit_cnt_d      = bit_cnt_q;
    serial_out_d   = serial_out_q;
    serial_valid_d = 1'b0;
    last_bit_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        serial_out_d = IDLE_LEVEL;
        if (accept) begin
          shreg_d   = parallel_in_i;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en_i) begin
          serial_out_d   = out_bit;
          shreg_d        = shreg_shifted;
          serial_valid_d = 1'b1;
          bit_cnt_d      = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_CNT) begin
            last_bit_d = 1'b1;
            bit_cnt_d  = '0;
            if (accept) begin
              shreg_d = parallel_in_i;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      shreg_q        <= '0;
      bit_cnt_q      <= '0;
      serial_out_q   <= IDLE_LEVEL;
      serial_valid_q <= 1'b0;
      last_bit_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      bit_cnt_q      <= bit_cnt_d;
      serial_out_q   <= serial_out_d;
      serial_valid_q <= serial_valid_d;
      last_bit_q     <= last_bit_d;
    end
  end

  assign serial_out_o   = serial_out_q;
  assign serial_valid_o = serial_valid_q;
  assign last_bit_o     = last_bit_q;
  assign busy_o         = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid;
  logic [7:0] parallel_in;
  logic       shift_en;

  logic m_rdy, m_so, m_sv, m_lb, m_busy;
  logic l_rdy, l_so, l_sv, l_lb, l_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_msb (
    .clk_i(clk), .reset_i(reset), .load_valid_i(load_valid), .load_ready_o(m_rdy),
    .parallel_in_i(parallel_in), .shift_en_i(shift_en), .serial_out_o(m_so),
    .serial_valid_o(m_sv), .last_bit_o(m_lb), .busy_o(m_busy));

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_lsb (
    .clk_i(clk), .reset_i(reset), .load_valid_i(load_valid), .load_ready_o(l_rdy),
    .parallel_in_i(parallel_in), .shift_en_i(shift_en), .serial_out_o(l_so),
    .serial_valid_o(l_sv), .last_bit_o(l_lb), .busy_o(l_busy));

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_valid = 1'b0; parallel_in = 8'h00; shift_en = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    total++; if ({m_so, m_sv, m_lb, m_busy} !== 4'b0000) begin
      bad++; $display("FAIL reset_msb_outs got=%b want=0000", {m_so, m_sv, m_lb, m_busy});
    end
    total++; if ({l_so, l_sv, l_lb, l_busy} !== 4'b1000) begin
      bad++; $display("FAIL reset_lsb_outs got=%b want=1000", {l_so, l_sv, l_lb, l_busy});
    end
    total++; if ({m_rdy, l_rdy} !== 2'b11) begin
      bad++; $display("FAIL reset_ready got=%b want=11", {m_rdy, l_rdy});
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] w = 8'hC1;
    load_valid = 1'b1; parallel_in = w; shift_en = 1'b1;
    tick();
    load_valid = 1'b0;
    total++; if ({m_busy, m_sv} !== 2'b10) begin
      bad++; $display("FAIL msb_accept busy_sv got=%b want=10", {m_busy, m_sv});
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      total++; if ({m_sv, m_so, m_lb} !== {1'b1, w[7-i], (i == 7)}) begin
        bad++; $display("FAIL msb_bit%0d sv_so_lb got=%b want=%b", i, {m_sv, m_so, m_lb}, {1'b1, w[7-i], (i == 7)});
      end
    end
    tick();
    total++; if ({m_sv, m_so, m_lb, m_busy} !== 4'b0000) begin
      bad++; $display("FAIL msb_after got=%b want=0000", {m_sv, m_so, m_lb, m_busy});
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] w = 8'hC1;
    load_valid = 1'b1; parallel_in = w; shift_en = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++; if ({l_sv, l_so, l_lb} !== {1'b1, w[i], (i == 7)}) begin
        bad++; $display("FAIL lsb_bit%0d sv_so_lb got=%b want=%b", i, {l_sv, l_so, l_lb}, {1'b1, w[i], (i == 7)});
      end
    end
    tick();
    total++; if ({l_sv, l_so, l_lb, l_busy} !== 4'b0100) begin
      bad++; $display("FAIL lsb_after got=%b want=0100", {l_sv, l_so, l_lb, l_busy});
    end
  endtask

  task automatic test_slow_tick();
    logic [7:0] w = 8'hC1;
    logic       held = 1'b0;
    logic       se_used;
    int         k = 0;
    load_valid = 1'b1; parallel_in = w; shift_en = 1'b0;
    tick();
    load_valid = 1'b0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      shift_en = (c % 3 == 2);
      se_used  = shift_en;
      tick();
      if (se_used) begin
        total++; if ({m_sv, m_so, m_lb} !== {1'b1, w[7-k], (k == 7)}) begin
          bad++; $display("FAIL slow_bit%0d sv_so_lb got=%b want=%b", k, {m_sv, m_so, m_lb}, {1'b1, w[7-k], (k == 7)});
        end
        held = w[7-k];
        k++;
      end else begin
        total++; if ({m_sv, m_so, m_lb} !== {1'b0, held, 1'b0}) begin
          bad++; $display("FAIL slow_hold_c%0d sv_so_lb got=%b want=%b", c, {m_sv, m_so, m_lb}, {1'b0, held, 1'b0});
        end
      end
    end
    total++; if (k != 8) begin
      bad++; $display("FAIL slow_bit_count got=%0d want=8", k);
    end
    shift_en = 1'b1;
    tick();
    total++; if ({m_sv, m_busy} !== 2'b00) begin
      bad++; $display("FAIL slow_after got=%b want=00", {m_sv, m_busy});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w = 16'hC13C;
    load_valid = 1'b1; parallel_in = 8'hC1; shift_en = 1'b1;
    tick();
    parallel_in = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      total++; if (m_rdy !== (i % 8 == 7)) begin
        bad++; $display("FAIL b2b_ready%0d got=%b want=%b", i, m_rdy, (i % 8 == 7));
      end
      tick();
      if (i == 7) load_valid = 1'b0;
      total++; if ({m_sv, m_so, m_lb} !== {1'b1, w[15-i], (i % 8 == 7)}) begin
        bad++; $display("FAIL b2b_bit%0d sv_so_lb got=%b want=%b", i, {m_sv, m_so, m_lb}, {1'b1, w[15-i], (i % 8 == 7)});
      end
    end
    tick();
    total++; if ({m_sv, m_busy, m_so} !== 3'b000) begin
      bad++; $display("FAIL b2b_after got=%b want=000", {m_sv, m_busy, m_so});
    end
  endtask

  task automatic test_blocked_load();
    logic [15:0] w = 16'hC1FF;
    load_valid = 1'b1; parallel_in = 8'hC1; shift_en = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin
        load_valid = 1'b1; parallel_in = 8'hFF;
        #1;
        total++; if (m_rdy !== 1'b0) begin
          bad++; $display("FAIL blocked_ready_cnt3 got=%b want=0", m_rdy);
        end
      end
      tick();
      if (i == 7) load_valid = 1'b0;
      total++; if ({m_sv, m_so, m_lb} !== {1'b1, w[15-i], (i % 8 == 7)}) begin
        bad++; $display("FAIL blocked_bit%0d sv_so_lb got=%b want=%b", i, {m_sv, m_so, m_lb}, {1'b1, w[15-i], (i % 8 == 7)});
      end
    end
    tick();
    total++; if ({m_sv, m_busy} !== 2'b00) begin
      bad++; $display("FAIL blocked_after got=%b want=00", {m_sv, m_busy});
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w = 8'h81;
    load_valid = 1'b1; parallel_in = 8'hC1; shift_en = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++; if ({m_busy, m_sv, m_so, m_lb, m_rdy} !== 5'b00001) begin
      bad++; $display("FAIL midreset_state got=%b want=00001", {m_busy, m_sv, m_so, m_lb, m_rdy});
    end
    load_valid = 1'b1; parallel_in = w;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++; if ({m_sv, m_so, m_lb} !== {1'b1, w[7-i], (i == 7)}) begin
        bad++; $display("FAIL midreset_bit%0d sv_so_lb got=%b want=%b", i, {m_sv, m_so, m_lb}, {1'b1, w[7-i], (i == 7)});
      end
    end
    tick();
    total++; if ({m_sv, m_busy} !== 2'b00) begin
      bad++; $display("FAIL midreset_after got=%b want=00", {m_sv, m_busy});
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_slow_tick();
    test_back_to_back();
    test_blocked_load();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
